sr_bank_ctrl: RTL and testbench



---
 rtl/sr_bank_ctrl_if.sv | 31 +++
 rtl/sr_bank_ctrl.sv | 114 +++++++++++
 tb/tb_sr_bank_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_bank_ctrl_if.sv
// Signal bundle between two requesters, the SR-bank controller and the SR flip-flop bank.
// The master side is the environment (requesters plus bank feedback); the slave side is the controller.
interface sr_bank_ctrl_if #(
  parameter int IW = 2
);
  localparam int N = 1 << IW;

  logic          req0;
  logic          req1;
  logic          op0;
  logic          op1;
  logic [IW-1:0] idx0;
  logic [IW-1:0] idx1;
  logic          ack0;
  logic          ack1;
  logic [N-1:0]  S;
  logic [N-1:0]  R;
  logic [N-1:0]  q_in;
  logic          busy;
  logic          err;

  modport master (
    output req0, req1, op0, op1, idx0, idx1, q_in,
    input  ack0, ack1, S, R, busy, err
  );

  modport slave (
    input  req0, req1, op0, op1, idx0, idx1, q_in,
    output ack0, ack1, S, R, busy, err
  );
endinterface

// File: rtl/sr_bank_ctrl.sv
// Two-requester, round-robin controller that sets or clears one bit of an SR flip-flop bank per
// operation: drive one cycle, release one cycle, then read back and acknowledge.
module sr_bank_ctrl #(
  parameter int IW = 2
) (
  input logic          clk,
  input logic          rst,
  sr_bank_ctrl_if.slave bus
);
  localparam int N = 1 << IW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    CHECK = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q;      // requester granted most recently
  logic          who_q;
  logic          op_q;
  logic [IW-1:0] idx_q;

  logic          grant_en;
  logic          grant_who;
  logic          sel_op;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  sel_onehot;

  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  r_q, r_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;

  // On a tie the requester that did not win last time is served; otherwise whoever is asking.
  assign grant_who  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign sel_op     = grant_who ? bus.op1  : bus.op0;
  assign sel_idx    = grant_who ? bus.idx1 : bus.idx0;
  assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;

  // S/R/ack are registered so the bank sees glitch-free drive; they are computed one cycle ahead.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d  = state_q;
    grant_en = 1'b0;
    s_d      = '0;
    r_d      = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_en = 1'b1;
          state_d  = DRIVE;
          if (sel_op) s_d = sel_onehot;
          else        r_d = sel_onehot;
        end
      end
      DRIVE: state_d = HOLD;
      HOLD: begin
        state_d = CHECK;
        ack0_d  = ~who_q;
        ack1_d  = who_q;
      end
      CHECK: begin
        state_d = IDLE;
        if (bus.q_in[idx_q] != op_q) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      s_q     <= '0;
      r_q     <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      if (grant_en) last_q <= grant_who;
    end
  end

  // Operation payload is frozen at grant so later req/op/idx changes cannot disturb it.
  always_ff @(posedge clk) begin
    // NOTE: these payload registers carry no reset: they are only read after a grant has loaded them.
    if (grant_en) begin
      who_q <= grant_who;
      op_q  <= sel_op;
      idx_q <= sel_idx;
    end
  end

  assign bus.S    = s_q;
  assign bus.R    = r_q;
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.err  = err_q;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: cycle table, hand-written corner sequences, and a randomized run checked
// against a transaction-level schedule model with a behavioural SR bank supplying q_in.
module tb_sr_bank_ctrl;
  localparam int IW = 2;
  localparam int N  = 1 << IW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_bank_ctrl_if #(.IW(IW)) bus ();
  sr_bank_ctrl #(.IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural SR bank plus an optional stuck-at overlay on its Q feedback.
  logic [N-1:0] bank       = '0;
  logic [N-1:0] stuck_mask = '0;
  logic [N-1:0] stuck_val  = '0;
  always @(posedge clk) bank <= (bank | bus.S) & ~bus.R;
  assign bus.q_in = (bank & ~stuck_mask) | (stuck_val & stuck_mask);

  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int idx3_cnt = 0;
  always @(posedge clk) begin
    if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
    if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
    if (bus.S[3] || bus.R[3]) idx3_cnt <= idx3_cnt + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rq0, input logic o0, input logic [IW-1:0] i0,
                       input logic rq1, input logic o1, input logic [IW-1:0] i1);
    rst      = r;
    bus.req0 = rq0; bus.op0 = o0; bus.idx0 = i0;
    bus.req1 = rq1; bus.op1 = o1; bus.idx1 = i1;
  endtask

  // One row = inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic          rst, req0, op0;
    logic [IW-1:0] idx0;
    logic          req1, op1;
    logic [IW-1:0] idx1;
    logic [N-1:0]  s, r;
    logic          ack0, ack1, busy, err;
  } vec_t;

  function automatic vec_t v(logic rs, logic rq0, logic o0, logic [IW-1:0] i0,
                             logic rq1, logic o1, logic [IW-1:0] i1,
                             logic [N-1:0] s, logic [N-1:0] r,
                             logic a0, logic a1, logic b, logic e);
    vec_t x;
    x.rst = rs; x.req0 = rq0; x.op0 = o0; x.idx0 = i0;
    x.req1 = rq1; x.op1 = o1; x.idx1 = i1;
    x.s = s; x.r = r; x.ack0 = a0; x.ack1 = a1; x.busy = b; x.err = e;
    return x;
  endfunction

  // Raise a request from idle, expect its ack three edges later, then drop it.
  task automatic do_op(input logic who, input logic op, input logic [IW-1:0] idx, input string name);
    int   waited = 0;
    logic seen   = 1'b0;
    if (who) begin bus.req1 = 1'b1; bus.op1 = op; bus.idx1 = idx; end
    else     begin bus.req0 = 1'b1; bus.op0 = op; bus.idx0 = idx; end
    while (!seen && waited < 8) begin
      step();
      waited++;
      seen = who ? bus.ack1 : bus.ack0;
    end
    check({name, "_ack"}, 32'(seen), 32'(1));
    check({name, "_latency"}, 32'(waited), 32'(3));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
  endtask

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int a0_snap, a1_snap, i3_snap;
    // ---------------- table-driven cycle vectors ----------------
    vecs[0]  = v(1, 0,0,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0);
    vecs[1]  = v(0, 1,1,2, 0,0,0, 4'b0100,4'b0000, 0,0,1,0);
    vecs[2]  = v(0, 1,1,2, 0,0,0, 4'b0000,4'b0000, 0,0,1,0);
    vecs[3]  = v(0, 1,1,2, 0,0,0, 4'b0000,4'b0000, 1,0,1,0);
    vecs[4]  = v(0, 0,0,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0);
    vecs[5]  = v(1, 0,0,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0);
    vecs[6]  = v(0, 1,1,0, 1,0,0, 4'b0001,4'b0000, 0,0,1,0);
    vecs[7]  = v(0, 1,1,0, 1,0,0, 4'b0000,4'b0000, 0,0,1,0);
    vecs[8]  = v(0, 1,1,0, 1,0,0, 4'b0000,4'b0000, 1,0,1,0);
    vecs[9]  = v(0, 0,0,0, 1,0,0, 4'b0000,4'b0000, 0,0,0,0);
    vecs[10] = v(0, 1,1,0, 1,0,0, 4'b0000,4'b0001, 0,0,1,0);
    vecs[11] = v(0, 1,1,0, 1,0,0, 4'b0000,4'b0000, 0,0,1,0);
    vecs[12] = v(0, 1,1,0, 1,0,0, 4'b0000,4'b0000, 0,1,1,0);
    vecs[13] = v(0, 1,1,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0);
    vecs[14] = v(0, 1,1,0, 0,0,0, 4'b0001,4'b0000, 0,0,1,0);
    vecs[15] = v(0, 1,1,0, 0,0,0, 4'b0000,4'b0000, 0,0,1,0);
    vecs[16] = v(0, 1,1,0, 0,0,0, 4'b0000,4'b0000, 1,0,1,0);
    vecs[17] = v(0, 0,0,0, 0,0,0, 4'b0000,4'b0000, 0,0,0,0);

    drive(1, 0,0,0, 0,0,0);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].req0, vecs[i].op0, vecs[i].idx0,
            vecs[i].req1, vecs[i].op1, vecs[i].idx1);
      step();
      check($sformatf("vec%0d.S", i),    32'(bus.S),    32'(vecs[i].s));
      check($sformatf("vec%0d.R", i),    32'(bus.R),    32'(vecs[i].r));
      check($sformatf("vec%0d.ack0", i), 32'(bus.ack0), 32'(vecs[i].ack0));
      check($sformatf("vec%0d.ack1", i), 32'(bus.ack1), 32'(vecs[i].ack1));
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d.err", i),  32'(bus.err),  32'(vecs[i].err));
    end

    // ---------------- sticky readback error ----------------
    drive(1, 0,0,0, 0,0,0); step(); drive(0, 0,0,0, 0,0,0);
    stuck_mask = 4'b1000; stuck_val = 4'b1000;
    do_op(1'b0, 1'b0, 2'd3, "stuck_clear");
    check("err_set", 32'(bus.err), 32'(1));
    stuck_mask = '0;
    do_op(1'b1, 1'b1, 2'd1, "clean_set");
    check("err_sticky1", 32'(bus.err), 32'(1));
    do_op(1'b0, 1'b0, 2'd1, "clean_clear");
    check("err_sticky2", 32'(bus.err), 32'(1));
    drive(1, 0,0,0, 0,0,0); step();
    check("err_rst", 32'(bus.err), 32'(0));

    // ---------------- reset during HOLD aborts the op ----------------
    drive(0, 1,1,1, 0,0,0); step();
    check("abort_drive_S", 32'(bus.S), 32'(4'b0010));
    step();
    check("abort_hold_busy", 32'(bus.busy), 32'(1));
    check("abort_hold_S", 32'(bus.S), 32'(0));
    a0_snap = ack0_cnt;
    drive(1, 1,1,1, 0,0,0); step();
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_S", 32'(bus.S), 32'(0));
    check("abort_R", 32'(bus.R), 32'(0));
    check("abort_ack0", 32'(bus.ack0), 32'(0));
    drive(0, 0,0,0, 0,0,0);
    repeat (6) step();
    check("abort_no_ack", 32'(ack0_cnt - a0_snap), 32'(0));

    // ---------------- req1 pulse while busy is ignored ----------------
    drive(1, 0,0,0, 0,0,0); step();
    a0_snap = ack0_cnt; a1_snap = ack1_cnt; i3_snap = idx3_cnt;
    drive(0, 1,1,0, 0,0,0); step();
    drive(0, 1,1,0, 1,1,3); step();
    drive(0, 1,1,0, 0,0,0); step();
    drive(0, 0,0,0, 0,0,0);
    repeat (6) step();
    check("pulse_ack0", 32'(ack0_cnt - a0_snap), 32'(1));
    check("pulse_no_ack1", 32'(ack1_cnt - a1_snap), 32'(0));
    check("pulse_no_idx3", 32'(idx3_cnt - i3_snap), 32'(0));

    // ---------------- randomized run against a schedule model ----------------
    begin
      logic [1:0]    pend;
      logic          win, wop, last_m;
      logic [IW-1:0] widx;
      int            d, p;
      logic [N-1:0]  es, er;
      logic          ea0, ea1, eb, drv;
      pend = '0; win = 1'b0; wop = 1'b0; widx = '0;
      last_m = 1'b1; d = -100; p = 0;
      drive(1, 0,0,0, 0,0,0); step(); rst = 1'b0;
      for (int c = 0; c < 1100; c++) begin
        for (int w = 0; w < 2; w++) begin
          logic inflight;
          logic o;
          logic [IW-1:0] ix;
          inflight = pend[w] && (win == 1'(w)) && (p >= d) && (p <= d + 2);
          o  = 1'($urandom_range(0, 1));
          ix = IW'($urandom_range(0, N - 1));
          if (inflight) begin
            if ($urandom_range(0, 1) == 0) begin
              if (w == 0) begin bus.op0 = o; bus.idx0 = ix; end
              else        begin bus.op1 = o; bus.idx1 = ix; end
            end
          end else if (pend[w]) begin
            if ($urandom_range(0, 31) == 0) begin
              pend[w] = 1'b0;
              if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
            end
          end else if (c < 1000 && $urandom_range(0, 3) == 0) begin
            pend[w] = 1'b1;
            if (w == 0) begin bus.req0 = 1'b1; bus.op0 = o; bus.idx0 = ix; end
            else        begin bus.req1 = 1'b1; bus.op1 = o; bus.idx1 = ix; end
          end
        end
        // Controller free in this cycle: pick the round-robin winner, it drives next cycle.
        if (p >= d + 3 && pend != 2'b00) begin
          win    = (pend == 2'b11) ? ~last_m : pend[1];
          last_m = win;
          wop    = win ? bus.op1  : bus.op0;
          widx   = win ? bus.idx1 : bus.idx0;
          d      = p + 1;
        end
        step();
        p++;
        drv = (p == d);
        es  = (drv && wop)  ? (N'(1) << widx) : '0;
        er  = (drv && !wop) ? (N'(1) << widx) : '0;
        ea0 = (p == d + 2) && !win;
        ea1 = (p == d + 2) && win;
        eb  = (p >= d) && (p <= d + 2);
        check("rnd.S",    32'(bus.S),    32'(es));
        check("rnd.R",    32'(bus.R),    32'(er));
        check("rnd.ack0", 32'(bus.ack0), 32'(ea0));
        check("rnd.ack1", 32'(bus.ack1), 32'(ea1));
        check("rnd.busy", 32'(bus.busy), 32'(eb));
        check("rnd.err",  32'(bus.err),  32'(0));
        check("rnd.s_and_r",   32'(bus.S & bus.R), 32'(0));
        check("rnd.one_drive", 32'($countones(bus.S | bus.R) <= 1), 32'(1));
        check("rnd.ack_excl",  32'(bus.ack0 & bus.ack1), 32'(0));
        if (p == d + 2) begin
          pend[win] = 1'b0;
          if (win) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        end
      end
      check("rnd.all_acked", 32'(pend), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
